uart_hamming_transmitter: RTL and testbench
===========================================

Name: uart_hamming_transmitter

Overview:
- Upstream feeder for the Hamming(7,4) UART receiver.
- Accepts a 4-bit nibble through a valid/ready handshake and Hamming(7,4)-encodes it into a 7-bit codeword.
- Serialises the frame as start (low), 7 codeword bits LSB first, stop (high), at CLKS_PER_BIT enabled clocks per bit.
- Output line idles high, so the receiver's start-detect, mid-bit sampling and stop check apply unchanged.

Parameters:
CLKS_PER_BIT, 8, enabled clock cycles per serial bit; must match the receiver's oversampling factor; legal range 2-16.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; all state advances only when high
data_in  input  4  nibble to send {d3,d2,d1,d0}
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a nibble this cycle
tx  output  1  serial line, registered, idles high
busy  output  1  high while a frame is on the line (state != IDLE)
state_out  output  2  current state, for debug: IDLE=0, START=1, DATA=2, STOP=3

Behaviour:
- Reset (asynchronous, while rst_n is low):
  - tx=1, state=IDLE, busy=0.
  - Shift register, bit counter and sample counter cleared.
  - Hold buffer emptied (when present).
  - A reset mid-frame aborts the frame; tx returns high immediately.
- ena low: every register holds its value, including tx. Handshakes are ignored (no accept).
- Encoding (combinational on the accepted nibble):
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p3 = d1^d2^d3.
  - Codeword c[6:0] = {d3,d2,d1,p3,d0,p2,p1}, so c[0]=p1 is transmitted first.
- Accept rule: data_valid & data_ready & ena at a rising edge. Without the optional feature, data_ready = (state==IDLE).
- IDLE: tx=1. On accept:
  - state goes to START; tx<=0 on the same edge.
  - Shift register <= c; sample counter <= 0; bit counter <= 0.
- START: tx=0 for CLKS_PER_BIT enabled cycles. On the last cycle (sample counter == CLKS_PER_BIT-1):
  - state goes to DATA; tx<=shift[0]; sample counter <= 0.
- DATA: each bit is held for CLKS_PER_BIT enabled cycles. At the end of each bit:
  - Shift right; tx<=next bit; bit counter increments.
  - After bit 6 completes: state goes to STOP, tx<=1.
- STOP: tx=1 for CLKS_PER_BIT enabled cycles, then state goes to IDLE.
- Frame timing:
  - A frame is 9*CLKS_PER_BIT enabled cycles (72 by default), measured from the accept edge to the STOP-to-IDLE edge.
  - Without the optional feature, back-to-back frames are separated by at least one enabled IDLE cycle of tx=1.
- data_in is sampled only at accept. Changes to data_in after accept do not affect the frame in flight.
- data_valid asserted while data_ready is low: no accept. The source must hold data_valid and data_in until it is accepted.
- Counter widths: sample counter is clog2(CLKS_PER_BIT) bits; bit counter is 3 bits. No wrap except the defined reset to 0 at bit boundaries.
- The state register must decode to IDLE from any illegal value; tx=1 in that case.

Optional Feature:
TX_HOLD_BUF_EN
- Defined: adds a one-entry hold buffer of 7-bit codeword plus full flag.
  - data_ready = !buf_full.
  - In IDLE with the buffer empty, an accept loads the shifter directly, exactly as in the base design.
  - In any non-IDLE state, an accept loads the buffer.
  - On the last STOP cycle with the buffer full: state goes directly to START, the shifter loads the buffer, buf_full clears, tx<=0. Gap between frames is zero cycles.
  - An accept on that same edge is impossible because data_ready is low while the buffer is full.
- Undefined: no buffer; data_ready = (state==IDLE); behaviour as in the base design.

Test Plan:
- Reset, then ena=1 and hold data_valid=0 -> tx=1, data_ready=1, busy=0, state_out=0 indefinitely.
- Send data_in=4'b1011 with CLKS_PER_BIT=8 -> tx sequence per 8-cycle bit is 0, 1,0,1,0,1,0,1, 1; the receiver stage outputs data_out=7'b1010101 with valid_out=1.
- Send 4'b0000, then 4'b0001 -> codewords 7'b0000000 and 7'b0000111. Frame length is exactly 72 enabled cycles; data_ready stays low throughout the frame.
- Toggle ena at a 50% duty cycle mid-frame -> each bit lasts 8 enabled cycles (16 clocks); tx is stable while ena=0.
- Assert rst_n=0 during DATA bit 3 -> tx=1 asynchronously, state_out=0; the next accept produces a clean full frame.
- With TX_HOLD_BUF_EN, present 4'b1011 then 4'b0001 back-to-back -> the second nibble is accepted during the first frame, data_ready=0 until the second frame starts, and the second START bit immediately follows the first STOP bit with no idle cycle.

Source files
------------

// File: rtl/uart_hamming_transmitter.sv
// rtl/uart_hamming_transmitter.sv - Hamming(7,4) encoder and UART frame serialiser; optional hold buffer via TX_HOLD_BUF_EN
module uart_hamming_transmitter #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic [1:0] state_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            tx_q, tx_d;
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      bit_q, bit_d;
    logic [CW-1:0]   smp_q, smp_d;
    logic [6:0]      codeword;
    logic            accept;
    logic            last_sample;

`ifdef TX_HOLD_BUF_EN
    logic [6:0]      buf_q, buf_d;
    logic            buf_full_q, buf_full_d;
`endif

    // Hamming(7,4) encode of the nibble on the input; c[0]=p1 goes out first
    always_comb begin
        codeword = {data_in[3], data_in[2], data_in[1],
                    data_in[1] ^ data_in[2] ^ data_in[3],
                    data_in[0],
                    data_in[0] ^ data_in[2] ^ data_in[3],
                    data_in[0] ^ data_in[1] ^ data_in[3]};
    end

`ifdef TX_HOLD_BUF_EN
    assign data_ready = !buf_full_q;
`else
    assign data_ready = (state_q == IDLE);
`endif

    assign accept      = data_valid & data_ready & ena;
    assign last_sample = (smp_q == LAST_SAMPLE);
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign state_out   = state_q;

    // Next-state and next-register values; everything holds while ena is low
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
`ifdef TX_HOLD_BUF_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
`ifdef TX_HOLD_BUF_EN
                    // A nibble parked in the buffer can only be seen here if it
                    // was taken on the final STOP edge; launch it right away.
                    if (buf_full_q) begin
                        state_d    = START;
                        tx_d       = 1'b0;
                        shift_d    = buf_q;
                        smp_d      = '0;
                        bit_d      = '0;
                        buf_full_d = 1'b0;
                    end else
`endif
                    if (accept) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = codeword;
                        smp_d   = '0;
                        bit_d   = '0;
                    end
                end
                START: begin
                    if (last_sample) begin
                        state_d = DATA;
                        tx_d    = shift_q[0];
                        smp_d   = '0;
                    end else begin
                        smp_d = smp_q + CW'(1);
                    end
                end
                DATA: begin
                    if (last_sample) begin
                        smp_d   = '0;
                        shift_d = {1'b0, shift_q[6:1]};
                        if (bit_q == 3'd6) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            bit_d   = '0;
                        end else begin
                            tx_d  = shift_q[1];
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        smp_d = smp_q + CW'(1);
                    end
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (last_sample) begin
                        smp_d   = '0;
                        state_d = IDLE;
`ifdef TX_HOLD_BUF_EN
                        if (buf_full_q) begin
                            state_d    = START;
                            tx_d       = 1'b0;
                            shift_d    = buf_q;
                            bit_d      = '0;
                            buf_full_d = 1'b0;
                        end
`endif
                    end else begin
                        smp_d = smp_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
`ifdef TX_HOLD_BUF_EN
            // While a frame is on the line, a new nibble is parked in the buffer
            if (accept && (state_q != IDLE)) begin
                buf_d      = codeword;
                buf_full_d = 1'b1;
            end
`endif
        end
    end

    // State and datapath registers; reset forces the line high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            shift_q <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
        end
    end

`ifdef TX_HOLD_BUF_EN
    // Hold buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// tb/tb_uart_hamming_transmitter.sv - directed self-checking bench for uart_hamming_transmitter
module tb_uart_hamming_transmitter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [1:0] state_out;

    int n_checks;
    int n_pass;

    uart_hamming_transmitter #(.CLKS_PER_BIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx, 1'b1);
        check({tag, "_state"}, state_out, 2'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, data_ready, 1'b1);
    endtask

    // Send one nibble and follow the whole frame, counting only enabled cycles.
    task automatic send_frame(input string tag, input logic [3:0] nib, input logic [6:0] cw,
                              input bit toggle, input bit hold_next, input logic [3:0] next_nib);
        int         w;
        int         en;
        logic [8:0] fr;
        logic [1:0] exp_st;
        fr         = {1'b1, cw, 1'b0};
        ena        = 1'b1;
        data_in    = nib;
        data_valid = 1'b1;
        w = 0;
        while (!data_ready && w < 200) begin
            step();
            w++;
        end
        check({tag, "_ready_pre"}, data_ready, 1'b1);
        step();
        if (hold_next) begin
            data_in = next_nib;
        end else begin
            data_valid = 1'b0;
            data_in    = ~nib;
        end
        en = 0;
        while (en < 72) begin
            exp_st = (en < 8) ? 2'd1 : (en < 64) ? 2'd2 : 2'd3;
            check({tag, "_tx"}, tx, fr[en / 8]);
            check({tag, "_state"}, state_out, exp_st);
            check({tag, "_busy"}, busy, 1'b1);
`ifndef TX_HOLD_BUF_EN
            check({tag, "_ready_low"}, data_ready, 1'b0);
`endif
            ena = toggle ? ~ena : 1'b1;
            if (ena) en++;
            step();
        end
        ena = 1'b1;
        check_idle({tag, "_end"});
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        data_in    = 4'd0;
        data_valid = 1'b0;
        repeat (3) step();
        check_idle("reset");

        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (20) step();
        check_idle("idle_hold");

        // Handshake ignored while ena is low
        ena        = 1'b0;
        data_in    = 4'b1011;
        data_valid = 1'b1;
        repeat (4) step();
        check("ena_low_state", state_out, 2'd0);
        check("ena_low_tx", tx, 1'b1);
        data_valid = 1'b0;
        ena        = 1'b1;
        step();

        send_frame("f1011", 4'b1011, 7'b1010101, 1'b0, 1'b0, 4'd0);
`ifndef TX_HOLD_BUF_EN
        send_frame("f0000", 4'b0000, 7'b0000000, 1'b0, 1'b1, 4'b0001);
        send_frame("f0001", 4'b0001, 7'b0000111, 1'b0, 1'b0, 4'd0);
`endif
        send_frame("f1111_ena", 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);

        // Reset in the middle of DATA bit 3 (c[3]=0 for 1011)
        data_in    = 4'b1011;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (36) step();
        check("pre_rst_tx", tx, 1'b0);
        check("pre_rst_state", state_out, 2'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_state", state_out, 2'd0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("post_rst");
        send_frame("f0110", 4'b0110, 7'b0110011, 1'b0, 1'b0, 4'd0);

`ifdef TX_HOLD_BUF_EN
        begin
            int         en;
            logic [8:0] fr1;
            logic [8:0] fr2;
            fr1        = {1'b1, 7'b1010101, 1'b0};
            fr2        = {1'b1, 7'b0000111, 1'b0};
            data_in    = 4'b1011;
            data_valid = 1'b1;
            step();
            data_in = 4'b0001;
            step();
            check("buf_ready_low", data_ready, 1'b0);
            data_valid = 1'b0;
            data_in    = 4'd0;
            en = 1;
            while (en < 72) begin
                check("buf_f1_tx", tx, fr1[en / 8]);
                check("buf_f1_ready", data_ready, 1'b0);
                step();
                en++;
            end
            check("buf_b2b_state", state_out, 2'd1);
            check("buf_b2b_tx", tx, 1'b0);
            check("buf_b2b_ready", data_ready, 1'b1);
            en = 0;
            while (en < 72) begin
                check("buf_f2_tx", tx, fr2[en / 8]);
                step();
                en++;
            end
            check_idle("buf_end");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
